wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter for two requesters.
// Requester A is the pipeline writeback and normally wins. Requester B is a
// multi-cycle unit; after STARVE_LIMIT consecutive refusals, B is granted.
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   a_valid/a_reg/a_data      - A request; a_stall (comb) = A refused this cycle
//   b_valid/b_reg/b_data      - B request; b_ready (comb) = B accepted this cycle
//   wr_en/wr_reg/wr_data      - registered register-file write port
//   b_wait                    - current B starvation count (debug)
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic [2:0]  b_wait
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [0:0] {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic                grant_a, grant_b;
  logic                wr_fire;
  logic [REG_W-1:0]    wr_reg_next;
  logic [DATA_W-1:0]   wr_data_next;

  // State, starvation counter and write-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= A_PRI;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      wr_en <= wr_fire;
      // Register 0 writes handshake but leave the write port untouched.
      if (wr_fire) begin
        wr_reg  <= wr_reg_next;
        wr_data <= wr_data_next;
      end
    end
  end

  // Grant selection, counter update and next state.
  always_comb begin
    state_next   = state;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    cnt_inc      = (cnt == CNT_W'(7)) ? cnt : cnt + CNT_W'(1);
    cnt_next     = '0;
    wr_fire      = 1'b0;
    wr_reg_next  = a_reg;
    wr_data_next = a_data;

    // Grants are suppressed while reset is high so nothing is in flight.
    if (!reset) begin
      case (state)
        A_PRI: begin
          grant_a = a_valid;
          grant_b = !a_valid && b_valid;
        end
        B_FORCE: begin
          grant_b = b_valid;
          grant_a = !b_valid && a_valid;
        end
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end

    if (b_valid && !grant_b) begin
      cnt_next = cnt_inc;
    end

    case (state)
      A_PRI: begin
        if (b_valid && !grant_b && (cnt_inc == CNT_W'(STARVE_LIMIT))) begin
          state_next = B_FORCE;
        end
      end
      B_FORCE: begin
        if (grant_b || !b_valid) begin
          state_next = A_PRI;
        end
      end
      default: state_next = A_PRI;
    endcase

    if (grant_b) begin
      wr_reg_next  = b_reg;
      wr_data_next = b_data;
    end
    wr_fire = (grant_a || grant_b) && (wr_reg_next != '0);
  end

  assign a_stall = a_valid && !grant_a;
  assign b_ready = b_valid && grant_b;
  assign b_wait  = cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with STARVE_LIMIT = 4.
module tb_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [2:0]  b_wait;

  int tests_run;
  int tests_failed;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .a_valid (a_valid),
    .a_reg   (a_reg),
    .a_data  (a_data),
    .a_stall (a_stall),
    .b_valid (b_valid),
    .b_reg   (b_reg),
    .b_data  (b_data),
    .b_ready (b_ready),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .b_wait  (b_wait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs then change and outputs settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b1;
    a_valid = 1'b1;
    a_reg   = 5'd1;
    a_data  = 32'h0;
    b_valid = 1'b1;
    b_reg   = 5'd2;
    b_data  = 32'h0;
    #1;
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_a_stall", 32'(a_stall), 32'd1);
    tick();
    tick();
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_reg",  32'(wr_reg),  32'd0);
    chk("rst_wr_data", wr_data,      32'd0);
    chk("rst_b_wait",  32'(b_wait),  32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    tick();

    // A alone: one-cycle write latency.
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234;
    #1;
    chk("a_only_stall", 32'(a_stall), 32'd0);
    chk("a_only_bready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("a_only_wr_en",   32'(wr_en),  32'd1);
    chk("a_only_wr_reg",  32'(wr_reg), 32'd5);
    chk("a_only_wr_data", wr_data,     32'h1234);
    tick();
    chk("a_only_pulse_end", 32'(wr_en),  32'd0);
    chk("a_only_hold_reg",  32'(wr_reg), 32'd5);

    // Contention: A wins four cycles, then B is forced.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hAAAA;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_b_wait",  32'(b_wait),  32'(i));
      chk("cont_a_stall", 32'(a_stall), 32'd0);
      chk("cont_b_ready", 32'(b_ready), 32'd0);
      tick();
      chk("cont_a_wr_reg", 32'(wr_reg), 32'd3);
      chk("cont_a_wr_en",  32'(wr_en),  32'd1);
    end
    chk("force_b_wait",  32'(b_wait),  32'd4);
    chk("force_b_ready", 32'(b_ready), 32'd1);
    chk("force_a_stall", 32'(a_stall), 32'd1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("force_wr_en",   32'(wr_en),   32'd1);
    chk("force_wr_reg",  32'(wr_reg),  32'd9);
    chk("force_wr_data", wr_data,      32'hBEEF);
    chk("resume_b_wait", 32'(b_wait),  32'd0);
    chk("resume_a_stall", 32'(a_stall), 32'd0);
    tick();
    chk("resume_wr_reg", 32'(wr_reg), 32'd3);

    // Register 0 from B: handshake only, write port holds.
    a_valid = 1'b0;
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    #1;
    chk("r0_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("r0_wr_en",   32'(wr_en),  32'd0);
    chk("r0_wr_reg",  32'(wr_reg), 32'd3);
    chk("r0_wr_data", wr_data,     32'hAAAA);

    // Reset mid-contention with cnt = 3.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hAAAA;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBEEF;
    tick();
    tick();
    tick();
    chk("mid_b_wait", 32'(b_wait), 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
    chk("mid_rst_a_stall", 32'(a_stall), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_b_wait",  32'(b_wait), 32'd0);
    chk("mid_rst_wr_en",   32'(wr_en),  32'd0);
    chk("mid_rst_wr_reg",  32'(wr_reg), 32'd0);
    chk("mid_rst_wr_data", wr_data,     32'd0);
    chk("post_rst_a_stall", 32'(a_stall), 32'd0);
    chk("post_rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("post_rst_wr_reg", 32'(wr_reg), 32'd3);
    chk("post_rst_wr_en",  32'(wr_en),  32'd1);

    // Clear counter, then same-register writes from A then forced B.
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("same_a_wr_data", wr_data, 32'h11);
      chk("same_a_wr_reg",  32'(wr_reg), 32'd7);
    end
    chk("same_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("same_b_wr_en",   32'(wr_en),  32'd1);
    chk("same_b_wr_reg",  32'(wr_reg), 32'd7);
    chk("same_b_wr_data", wr_data,     32'h22);

    // Idle for ten cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_wr_en",   32'(wr_en),   32'd0);
      chk("idle_b_wait",  32'(b_wait),  32'd0);
      chk("idle_a_stall", 32'(a_stall), 32'd0);
      chk("idle_b_ready", 32'(b_ready), 32'd0);
    end

    // B withdrawn before grant: counter clears, no write.
    a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h66;
    tick();
    tick();
    b_valid = 1'b0;
    #1;
    chk("wd_b_wait", 32'(b_wait), 32'd2);
    tick();
    a_valid = 1'b0;
    chk("wd_b_wait_clr", 32'(b_wait), 32'd0);
    chk("wd_wr_reg",     32'(wr_reg), 32'd4);
    tick();
    chk("wd_no_write", 32'(wr_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
